// File: rtl/serial_shift_engine.sv
`default_nettype none
// ============================================================================
//  Module      : serial_shift_engine
//  Description : Bit-serial transmit/receive engine. It gates a downstream
//                clock divider, samples its divided clock in the system clock
//                domain and shifts a parallel word out on sdo, one bit per
//                serial period. Optional receive capture of sdi is enabled by
//                defining SERIAL_SHIFT_ENGINE_RX_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_shift_engine #(
    parameter int   DATA_WIDTH = 8,
    parameter logic IDLE_STATE = 1'b0,
    parameter logic MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  divider_enable,
    input  logic                  sclk_in,
    output logic                  sdo,
    input  logic                  sdi,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int         c_CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic                  r_sclk_q;
    logic                  w_lead;
    logic                  w_trail;
    logic                  w_accept;
    logic                  w_last_trail;
    logic [c_CNT_W-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-1:0] w_tx_shifted;
    logic                  w_next_bit;
    logic                  r_sdo;

    // Edge classification against the registered copy of the serial clock
    always_comb begin
        w_lead       = (sclk_in != r_sclk_q) && (sclk_in != IDLE_STATE);
        w_trail      = (sclk_in != r_sclk_q) && (sclk_in == IDLE_STATE);
        w_accept     = (r_state == c_ST_IDLE) && tx_valid;
        w_last_trail = (r_state == c_ST_SHIFT) && w_trail && (r_count == c_CNT_W'(1));
        // Shift operators keep this valid for a one-bit word
        w_tx_shifted = MSB_FIRST ? (r_tx_shift << 1) : (r_tx_shift >> 1);
        w_next_bit   = MSB_FIRST ? w_tx_shifted[DATA_WIDTH-1] : w_tx_shifted[0];
    end

    // Serial clock sampling register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_q <= IDLE_STATE;
        end else begin
            r_sclk_q <= sclk_in;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (tx_valid) w_next_state = c_ST_SHIFT;
            c_ST_SHIFT: if (w_last_trail) w_next_state = c_ST_DONE;
            c_ST_DONE:  w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        tx_ready       = 1'b0;
        divider_enable = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        rx_valid       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                tx_ready = 1'b1;
            end
            c_ST_SHIFT: begin
                divider_enable = 1'b1;
                busy           = 1'b1;
            end
            c_ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
`ifdef SERIAL_SHIFT_ENGINE_RX_EN
                rx_valid = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Transmit shift register, bit counter and sdo; sdo holds between frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shift <= '0;
            r_count    <= '0;
            r_sdo      <= 1'b0;
        end else if (w_accept) begin
            r_tx_shift <= tx_data;
            r_count    <= c_CNT_W'(DATA_WIDTH);
            r_sdo      <= MSB_FIRST ? tx_data[DATA_WIDTH-1] : tx_data[0];
        end else if ((r_state == c_ST_SHIFT) && w_trail) begin
            r_count <= r_count - 1'b1;
            if (r_count > c_CNT_W'(1)) begin
                r_tx_shift <= w_tx_shifted;
                r_sdo      <= w_next_bit;
            end
        end
    end

    assign sdo = r_sdo;

`ifdef SERIAL_SHIFT_ENGINE_RX_EN
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic [DATA_WIDTH:0]   w_rx_ext;
    logic [DATA_WIDTH-1:0] w_rx_shifted;

    // Receive shift in the same bit order as transmit
    always_comb begin
        w_rx_ext     = MSB_FIRST ? {r_rx_shift, sdi} : {sdi, r_rx_shift};
        w_rx_shifted = MSB_FIRST ? w_rx_ext[DATA_WIDTH-1:0] : w_rx_ext[DATA_WIDTH:1];
    end

    // Capture sdi on leading edges; publish the word as DONE is entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_shift <= '0;
            r_rx_data  <= '0;
        end else begin
            if ((r_state == c_ST_SHIFT) && w_lead) begin
                r_rx_shift <= w_rx_shifted;
            end
            if (w_last_trail) begin
                r_rx_data <= r_rx_shift;
            end
        end
    end

    assign rx_data = r_rx_data;
`else
    logic w_unused;
    assign w_unused = ^{sdi, w_lead};
    assign rx_data  = '0;
`endif

endmodule
`default_nettype wire
